muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle integer multiply/divide unit with the architectural HI/LO registers. It sits directly downstream of the register file. The decode stage routes `read_data_1` (rs) and `read_data_2` (rt) to it for MULT/MULTU/DIV/DIVU. It accepts MTHI/MTLO writes, and supplies HI/LO to the write-back mux for MFHI/MFLO. A shared iterative datapath keeps area small, and a busy/done handshake lets the controller stall.

## Interface

Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: launch an operation; sampled only in IDLE.
- `op` in 2: `00` MULTU, `01` MULT, `10` DIVU, `11` DIV.
- `operand_a` in `WIDTH`: rs value (multiplicand / dividend).
- `operand_b` in `WIDTH`: rt value (multiplier / divisor).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `write_data` in `WIDTH`: MTHI/MTLO data.
- `busy` out 1: operation in progress (not IDLE).
- `done` out 1: one-cycle pulse; HI/LO hold new results.
- `hi` out `WIDTH`: HI register (remainder / upper product).
- `lo` out `WIDTH`: LO register (quotient / lower product).

## Operation

State machine:
- IDLE → CALC when `start` is 1. At the same edge: latch `op`; latch `|operand_a|` and `|operand_b|` (unsigned ops: raw values); record the result-sign flags; clear the iteration counter.
- CALC → CALC for `WIDTH` iterations, one per cycle.
  - Multiply: shift-add over a 2·`WIDTH` accumulator.
  - Divide: restoring step using a (`WIDTH`+1)-bit subtract.
- CALC → FIX once the counter reaches `WIDTH`−1.
- FIX → DONE. At this edge, apply sign correction and write HI/LO.
- DONE → IDLE unconditionally. `done`=1 only in DONE.

Sign rules:
- Product: negate the 2·`WIDTH` result if the operand signs differ.
- Quotient: negate if the signs differ.
- Remainder: takes the sign of the dividend.

Boundary conditions:
- Divide by zero (either divide op): LO = all ones, HI = `operand_a` unchanged. Latency is the normal latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- `start` while not IDLE: ignored.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE with `start`=0.
  - If `start`=1 in the same cycle, `start` wins and the write is dropped.
  - Writes while busy are dropped.
- `hi_we` and `lo_we` both asserted: both registers take `write_data`.
- `rst_n`=0 at any edge, including mid-operation: state → IDLE; HI, LO, counter and accumulators cleared; any in-flight result is discarded.

## Timing

- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.
- `start` sampled at edge E:
  - `busy`=1 from E until the edge E+`WIDTH`+2.
  - `hi`/`lo` update at edge E+`WIDTH`+1.
  - `done`=1 for the single cycle between edges E+`WIDTH`+1 and E+`WIDTH`+2.
  - For `WIDTH`=32, the result is visible 33 edges after the start edge.
- Back-to-back operations: the next `start` is accepted no earlier than edge E+`WIDTH`+2 (the first IDLE cycle).
- MTHI/MTLO: `hi`/`lo` reflect `write_data` one edge after `hi_we`/`lo_we`.
- `hi` and `lo` are register outputs with no combinational path from any input.

## Structure

- Package `muldiv_pkg` holds:
  - op encodings: `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`;
  - state enum: IDLE, CALC, FIX, DONE.
  - The decode block imports the same package.
- One sub-module, `muldiv_addsub`: the (`WIDTH`+1)-bit adder/subtractor shared by the multiply add step and the divide trial subtract.
- Counter width is `$clog2(WIDTH)`.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` pulses exactly 33 edges after the start edge; `busy` high throughout.
- MULT −3 × 7 (0xFFFFFFFD, 0x00000007) → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064, with normal latency.
- Sequence of three checks:
  - MTHI 0x12345678 in IDLE → `hi`=0x12345678 next cycle.
  - MTLO asserted together with `start` → write dropped; the operation's result is written.
  - `start` asserted mid-CALC → ignored; the first result is unchanged.
- Reset mid-operation: pull `rst_n` low at iteration 10 of a MULT → `busy`=0, `hi`=`lo`=0 after that edge, and no `done` pulse. A fresh MULTU 6 × 7 afterwards → LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its decode logic.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_unit_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the multiply add step and the
// divide trial subtract. carry=1 on a subtract means no borrow (a >= b).
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           carry
);

  // Two's-complement subtract folds into the add via inverted b and carry-in.
  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(WIDTH + 1){1'b0}}, sub};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are reduced to magnitudes at launch, iterated unsigned for WIDTH
// cycles, and sign-corrected in the FIX cycle when HI/LO are written.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;
  logic is_div_q, is_div_d;
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0] as_a, as_b, as_sum;
  logic as_carry;
  logic [2*WIDTH-1:0] prod;

  // Multiply adds the multiplicand to the upper half; divide trial-subtracts
  // the divisor from the partial remainder with the next dividend bit shifted in.
  assign as_a = is_div_q ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
  assign as_b = {1'b0, m_q};

  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (as_a),
    .b     (as_b),
    .sub   (is_div_q),
    .sum   (as_sum),
    .carry (as_carry)
  );

  // Decode the requested op and take operand magnitudes for signed ops.
  always_comb begin
    op_div    = (op == OP_DIVU) || (op == OP_DIV);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed & operand_a[WIDTH-1];
    b_neg     = op_signed & operand_b[WIDTH-1];
    a_mag     = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
    b_mag     = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;
  end

  // Next-state, iteration datapath and HI/LO update.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod     = {acc_hi_q, acc_lo_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          is_div_d = op_div;
          // A zero divisor keeps the all-ones quotient unnegated.
          q_neg_d  = (a_neg ^ b_neg) & ~(op_div & (operand_b == '0));
          r_neg_d  = a_neg;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          m_d      = b_mag;
        end else begin
          if (hi_we) hi_d = write_data;
          if (lo_we) lo_d = write_data;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = FIX;
        if (is_div_q) begin
          acc_hi_d = as_carry ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], as_carry};
        end else if (acc_lo_q[0]) begin
          {acc_hi_d, acc_lo_d} = {as_sum, acc_lo_q[WIDTH-1:1]};
        end else begin
          {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          lo_d = q_neg_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
          hi_d = r_neg_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
        end else begin
          if (q_neg_q) prod = ~prod + (2 * WIDTH)'(1);
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         hi_we, lo_we;
  logic [W-1:0] write_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op_i),
    .operand_a  (a_i),
    .operand_b  (b_i),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, expv);
    end
  endtask

  // Reference: HI/LO straight from integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b00) begin
      p = {32'b0, a} * {32'b0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (o == 2'b01) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a;
      l = '1;
    end else if (o == 2'b10) begin
      l = a / b;
      h = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  // Launch one op and follow it to completion. intrude>0 pokes start/hi_we
  // at that cycle of CALC; lo_w drives MTLO together with start.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intrude, input logic lo_w);
    logic [W-1:0] eh, el;
    int lat;
    logic busy_ok;
    model(o, a, b, eh, el);
    @(negedge clk);
    op_i = o; a_i = a; b_i = b; start = 1'b1;
    lo_we = lo_w; write_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    check_eq("lo_held_at_start", 64'(lo), 64'(exp_lo));
    lat = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      if (n == intrude) begin
        start = 1'b1; op_i = ~o; a_i = ~a; b_i = 32'h3;
        hi_we = 1'b1; write_data = 32'h5555AAAA;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check_eq("done_latency", 64'(lat), 64'(W + 1));
    check_eq("busy_throughout", 64'(busy_ok & busy), 64'd1);
    check_eq("hi_result", 64'(hi), 64'(eh));
    check_eq("lo_result", 64'(lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
    @(posedge clk); #1;
    check_eq("busy_after_done", 64'(busy), 64'd0);
    check_eq("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    logic saw_done;
    rst_n = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    hi_we = 1'b0; lo_we = 1'b0; write_data = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    check_eq("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
    check_eq("multu_max_lo", 64'(lo), 64'h00000001);
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 0, 1'b0);
    check_eq("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
    check_eq("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 0, 1'b0);
    check_eq("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
    check_eq("div_neg_hi", 64'(hi), 64'hFFFFFFFF);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    check_eq("div_ovf_lo", 64'(lo), 64'h80000000);
    check_eq("div_ovf_hi", 64'(hi), 64'h0);
    run_op(2'b10, 32'd100, 32'd0, 0, 1'b0);
    check_eq("divu_zero_lo", 64'(lo), 64'hFFFFFFFF);
    check_eq("divu_zero_hi", 64'(hi), 64'h00000064);
    run_op(2'b11, 32'hFFFFFF00, 32'd0, 0, 1'b0);

    // MTHI / MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; write_data = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    exp_hi = 32'h12345678;
    check_eq("mthi_idle", 64'(hi), 64'h12345678);
    check_eq("mthi_lo_untouched", 64'(lo), 64'(exp_lo));
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    exp_hi = 32'hCAFEF00D; exp_lo = 32'hCAFEF00D;
    check_eq("mthilo_hi", 64'(hi), 64'hCAFEF00D);
    check_eq("mthilo_lo", 64'(lo), 64'hCAFEF00D);

    // MTLO with start dropped; start mid-CALC ignored
    run_op(2'b10, 32'd1000, 32'd7, 0, 1'b1);
    run_op(2'b01, 32'h00012345, 32'hFFFF0003, 12, 1'b0);

    // Reset at iteration 10 of a MULT
    @(negedge clk);
    op_i = 2'b01; a_i = 32'hFFFFFFFB; b_i = 32'd1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_eq("midrst_no_done", 64'(saw_done), 64'd0);
    run_op(2'b00, 32'd6, 32'd7, 0, 1'b0);
    check_eq("after_rst_lo", 64'(lo), 64'd42);
    check_eq("after_rst_hi", 64'(hi), 64'd0);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = '1; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(ro, ra, rb, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
